// File: rtl/jk_seq_pkg.sv
// Shared types, command encodings and the JK next-state rule for the step sequencer.
package jk_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // {j,k} command encodings held in the step table
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   function automatic logic jk_next(input logic q, input logic [1:0] cmd);
      case (cmd)
         JK_HOLD: return q;
         JK_RST:  return 1'b0;
         JK_SET:  return 1'b1;
         default: return ~q;
      endcase
   endfunction

endpackage

// File: rtl/jk_seq_ctrl_tick_prescaler.sv
// Free-running divider producing a one-cycle tick enable every DIV_MAX+1 cycles while enabled.
module tick_prescaler #(
   parameter int DIV_MAX = 20000000,
   parameter int CNT_W   = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] DIV_VAL = CNT_W'(DIV_MAX);

   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap = (r_cnt == DIV_VAL);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr || !en || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = en && w_wrap;

endmodule

// File: rtl/jk_seq_ctrl.sv
// JK flip-flop sequencer: a prescaled tick walks a programmable {j,k} step table.
module jk_seq_ctrl
   import jk_seq_pkg::*;
#(
   parameter int DIV_MAX = 20000000,
   parameter int CNT_W   = 27,
   parameter int NSTEP   = 8,
   parameter int STEP_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   input  logic [STEP_W-1:0] len,
   input  logic              prog_we,
   input  logic [STEP_W-1:0] prog_addr,
   input  logic [1:0]        prog_data,
   output logic              j_out,
   output logic              k_out,
   output logic              q,
   output logic              tick,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_idx
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_table [NSTEP];
   logic [STEP_W-1:0] r_step_idx;
   logic [STEP_W-1:0] r_len_lat;
   logic              r_loop_lat;
   logic              r_q;

   logic              w_tick;
   logic              w_in_run;
   logic              w_start_ok;
   logic              w_stop_ok;
   logic              w_adv;
   logic              w_last;
   logic [1:0]        w_cmd;

   assign w_in_run   = (r_state == RUN);
   assign w_start_ok = (r_state == IDLE) && start;
   assign w_stop_ok  = w_in_run && stop;
   // stop beats a coincident tick, so the table is not applied on that edge
   assign w_adv      = w_tick && !stop;
   assign w_last     = (r_step_idx == r_len_lat);
   assign w_cmd      = r_table[r_step_idx];

   tick_prescaler #(
      .DIV_MAX (DIV_MAX),
      .CNT_W   (CNT_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_in_run),
      .clr   (w_stop_ok),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: default assigned first so no path through the case leaves a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = RUN;
         RUN: begin
            if (stop) begin
               w_state_nxt = IDLE;
            end else if (w_tick && w_last && !r_loop_lat) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: the table is flops, not RAM, precisely so reset can clear every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSTEP; i++) begin
            r_table[i] <= JK_HOLD;
         end
      end else if ((r_state == IDLE) && prog_we) begin
         r_table[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step_idx <= '0;
         r_len_lat  <= '0;
         r_loop_lat <= 1'b0;
         r_q        <= 1'b0;
      end else if (w_start_ok) begin
         r_step_idx <= '0;
         r_len_lat  <= len;
         r_loop_lat <= loop;
      end else if (w_stop_ok) begin
         r_step_idx <= '0;
      end else if (w_adv) begin
         r_q <= jk_next(r_q, w_cmd);
         if (!w_last) begin
            r_step_idx <= r_step_idx + 1'b1;
         end else if (r_loop_lat) begin
            r_step_idx <= '0;
         end
      end
   end

   assign j_out    = w_in_run & w_cmd[1];
   assign k_out    = w_in_run & w_cmd[0];
   assign q        = r_q;
   assign tick     = w_tick;
   assign busy     = w_in_run;
   assign done     = (r_state == DONE);
   assign step_idx = r_step_idx;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl: two instances (DIV_MAX=3 and DIV_MAX=0) driven alike, checked against a cycle model.
module tb_jk_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       loop;
   logic [2:0] len;
   logic       prog_we;
   logic [2:0] prog_addr;
   logic [1:0] prog_data;

   logic       j3, k3, q3, tick3, busy3, done3;
   logic [2:0] idx3;
   logic       j0, k0, q0, tick0, busy0, done0;
   logic [2:0] idx0;

   int total = 0;
   int bad   = 0;

   jk_seq_ctrl #(.DIV_MAX(3), .CNT_W(2), .NSTEP(8), .STEP_W(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop), .len(len),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .j_out(j3), .k_out(k3), .q(q3), .tick(tick3), .busy(busy3), .done(done3),
      .step_idx(idx3)
   );

   jk_seq_ctrl #(.DIV_MAX(0), .CNT_W(1), .NSTEP(8), .STEP_W(3)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop), .len(len),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .j_out(j0), .k_out(k0), .q(q0), .tick(tick0), .busy(busy0), .done(done0),
      .step_idx(idx0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d at %0t", name, got, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 running, 2 finished; m_run counts cycles spent running
   int       m_mode [2];
   int       m_run  [2];
   int       m_idx  [2];
   int       m_len  [2];
   bit       m_loop [2];
   bit       m_q    [2];
   bit [1:0] m_tab  [2][8];
   int       div_of [2] = '{3, 0};
   bit       m_t;

   function automatic bit apply_cmd(input bit cur, input bit [1:0] cmd);
      if (cmd == 2'b01) return 1'b0;
      if (cmd == 2'b10) return 1'b1;
      if (cmd == 2'b11) return !cur;
      return cur;
   endfunction

   function automatic bit model_tick(input int d);
      return (m_mode[d] == 1) && ((m_run[d] % (div_of[d] + 1)) == div_of[d]);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_mode[d] = 0;
         m_run[d]  = 0;
         m_idx[d]  = 0;
         m_len[d]  = 0;
         m_loop[d] = 1'b0;
         m_q[d]    = 1'b0;
         for (int a = 0; a < 8; a++) m_tab[d][a] = 2'b00;
      end
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_t = model_tick(d);
            case (m_mode[d])
               0: begin
                  if (prog_we) m_tab[d][prog_addr] = prog_data;
                  if (start) begin
                     m_mode[d] = 1;
                     m_run[d]  = 0;
                     m_idx[d]  = 0;
                     m_len[d]  = int'(len);
                     m_loop[d] = loop;
                  end
               end
               1: begin
                  if (stop) begin
                     m_mode[d] = 0;
                     m_idx[d]  = 0;
                  end else begin
                     if (m_t) begin
                        m_q[d] = apply_cmd(m_q[d], m_tab[d][m_idx[d]]);
                        if (m_idx[d] < m_len[d]) m_idx[d] = m_idx[d] + 1;
                        else if (m_loop[d])      m_idx[d] = 0;
                        else                     m_mode[d] = 2;
                     end
                     m_run[d] = m_run[d] + 1;
                  end
               end
               default: m_mode[d] = 0;
            endcase
         end
      end
   end

   logic [8:0] act [2];
   assign act[0] = {j3, k3, q3, tick3, busy3, done3, idx3};
   assign act[1] = {j0, k0, q0, tick0, busy0, done0, idx0};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         automatic bit  running = (m_mode[d] == 1);
         automatic bit [1:0] cmd = m_tab[d][m_idx[d]];
         automatic string sfx = (d == 0) ? "d3" : "d0";
         check({"m_j_",    sfx}, int'(act[d][8]),   running ? int'(cmd[1]) : 0);
         check({"m_k_",    sfx}, int'(act[d][7]),   running ? int'(cmd[0]) : 0);
         check({"m_q_",    sfx}, int'(act[d][6]),   int'(m_q[d]));
         check({"m_tick_", sfx}, int'(act[d][5]),   int'(model_tick(d)));
         check({"m_busy_", sfx}, int'(act[d][4]),   int'(running));
         check({"m_done_", sfx}, int'(act[d][3]),   (m_mode[d] == 2) ? 1 : 0);
         check({"m_idx_",  sfx}, int'(act[d][2:0]), m_idx[d]);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic prog(input logic [2:0] a, input logic [1:0] dat);
      prog_we = 1'b1; prog_addr = a; prog_data = dat;
      step(1);
      prog_we = 1'b0;
   endtask

   task automatic start_seq(input logic [2:0] l, input logic lp);
      start = 1'b1; len = l; loop = lp;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; len = '0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      step(2);
      check("rst_q3", q3, 0);
      check("rst_busy3", busy3, 0);
      check("rst_idx3", idx3, 0);
      check("rst_tick0", tick0, 0);
      rst_n = 1'b1;
      step(1);

      // 1: SET,TOG,TOG,RST once through
      prog(3'd0, 2'b10); prog(3'd1, 2'b11); prog(3'd2, 2'b11); prog(3'd3, 2'b01);
      start_seq(3'd3, 1'b0);
      step(3);
      check("t1_tick_c4", tick3, 1);
      check("t1_q_c4", q3, 0);
      check("t1_j_c4", j3, 1);
      check("t1_k_c4", k3, 0);
      step(1);
      check("t1_q_c5", q3, 1);
      check("t1_idx_c5", idx3, 1);
      check("t1_tick_c5", tick3, 0);
      step(4);
      check("t1_q_c9", q3, 0);
      step(4);
      check("t1_q_c13", q3, 1);
      step(3);
      check("t1_tick_c16", tick3, 1);
      check("t1_idx_c16", idx3, 3);
      step(1);
      check("t1_done_c17", done3, 1);
      check("t1_busy_c17", busy3, 0);
      check("t1_q_c17", q3, 0);
      step(1);
      check("t1_done_c18", done3, 0);

      // 2: looping, wrap then stop
      start_seq(3'd3, 1'b1);
      step(16);
      check("t2_idx_wrap", idx3, 0);
      check("t2_busy_wrap", busy3, 1);
      check("t2_done_wrap", done3, 0);
      step(4);
      check("t2_q_c21", q3, 1);
      step(1);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("t2_busy_stop", busy3, 0);
      check("t2_q_stop", q3, 1);
      check("t2_idx_stop", idx3, 0);
      check("t2_done_stop", done3, 0);

      // 3: stop coincident with a TOG tick while q=1
      start_seq(3'd3, 1'b1);
      step(7);
      check("t3_tick_c8", tick3, 1);
      check("t3_idx_c8", idx3, 1);
      check("t3_q_c8", q3, 1);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("t3_q_after", q3, 1);
      check("t3_idx_after", idx3, 0);
      check("t3_busy_after", busy3, 0);

      // 4: writes during RUN are dropped; write together with start lands
      prog(3'd0, 2'b01);
      start_seq(3'd0, 1'b0);
      prog_we = 1'b1; prog_addr = 3'd0; prog_data = 2'b10;
      step(1);
      prog_we = 1'b0;
      step(2);
      check("t4_j_run", j3, 0);
      check("t4_k_run", k3, 1);
      step(1);
      check("t4_q_rst", q3, 0);
      check("t4_done", done3, 1);
      step(1);
      start_seq(3'd0, 1'b0);
      check("t4_rb_j", j3, 0);
      check("t4_rb_k", k3, 1);
      step(4);
      check("t4_rb_q", q3, 0);
      step(1);
      prog_we = 1'b1; prog_addr = 3'd0; prog_data = 2'b11;
      start = 1'b1; len = 3'd0; loop = 1'b0;
      step(1);
      prog_we = 1'b0; start = 1'b0;
      check("t4_new_j", j3, 1);
      check("t4_new_k", k3, 1);
      step(4);
      check("t4_new_q", q3, 1);
      step(1);

      // 5: DIV_MAX=0, single TOG step looping
      rst_n = 1'b0;
      step(1);
      check("t5_rst_q0", q0, 0);
      check("t5_rst_q3", q3, 0);
      rst_n = 1'b1;
      step(1);
      prog(3'd0, 2'b11);
      start_seq(3'd0, 1'b1);
      check("t5_busy0", busy0, 1);
      for (int i = 0; i < 6; i++) begin
         check("t5_tick0", tick0, 1);
         check("t5_q0", q0, i % 2);
         step(1);
      end
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("t5_busy0_stop", busy0, 0);
      check("t5_tick0_stop", tick0, 0);

      // 6: asynchronous reset mid-run, then an unloaded table
      prog(3'd0, 2'b10);
      start_seq(3'd3, 1'b0);
      step(9);
      check("t6_q_pre", q3, 1);
      check("t6_idx_pre", idx3, 2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_q_async", q3, 0);
      check("t6_busy_async", busy3, 0);
      check("t6_idx_async", idx3, 0);
      check("t6_j_async", j3, 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      start_seq(3'd3, 1'b0);
      step(4);
      check("t6_q_c5", q3, 0);
      check("t6_idx_c5", idx3, 1);
      step(12);
      check("t6_done", done3, 1);
      check("t6_q_done", q3, 0);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
